// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and register-file write port for
// the five-stage RV32I pipeline. Aligns/extends load data, selects the
// write-back source, and counts retired instructions. All outputs are flops.
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [31:0]      i_instruct,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_alu_data,
  input  logic [31:0]      i_ld_data,
  input  logic             i_rd_wren,
  input  logic [1:0]       i_wb_sel,
  output logic             o_rd_wren,
  output logic [4:0]       o_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic             o_wb_valid,
  output logic [31:0]      o_wb_pc,
  output logic [CNT_W-1:0] o_instret
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Extract the addressed byte/halfword from the LSU word and extend it.
  // LW and the reserved encodings pass the whole word through untouched.
  function automatic logic [31:0] align_load(input logic [2:0]  funct3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext_s;
    logic [31:0]        res;
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfword loads ignore address bit 0 (misalignment handled upstream).
    half_sel = off[1] ? word[31:16] : word[15:0];
    byte_s   = byte_sel;
    half_s   = half_sel;
    ext_s    = '0;
    res      = word;
    case (funct3)
      F3_LB: begin
        ext_s = byte_s;
        res   = ext_s;
      end
      F3_LBU: res = {24'h0, byte_sel};
      F3_LH: begin
        ext_s = half_s;
        res   = ext_s;
      end
      F3_LHU:  res = {16'h0, half_sel};
      default: res = word;
    endcase
    return res;
  endfunction

  logic [4:0]  w_rd_addr;
  logic [2:0]  w_funct3;
  logic        w_rd_wren;
  logic [31:0] w_ld_aligned;
  logic [31:0] w_link;
  logic [31:0] w_rd_data;
  logic        w_load_en;
  logic        w_retire;
  logic        w_unused_bits;

  logic             r_rd_wren_p1;
  logic [4:0]       r_rd_addr_p1;
  logic [31:0]      r_rd_data_p1;
  logic             r_wb_valid_p1;
  logic [31:0]      r_wb_pc_p1;
  logic [CNT_W-1:0] r_instret;

  assign w_rd_addr     = i_instruct[11:7];
  assign w_funct3      = i_instruct[14:12];
  assign w_unused_bits = &{1'b0, i_instruct[31:15], i_instruct[6:0]};

  // Writes to x0 are dropped here so the register file never sees them.
  assign w_rd_wren    = i_valid & i_rd_wren & (w_rd_addr != 5'd0);
  assign w_ld_aligned = align_load(w_funct3, i_alu_data[1:0], i_ld_data);
  assign w_link       = i_pc + 32'd4;

  // A normal edge loads the pipeline register; flush beats stall.
  assign w_load_en = ~i_flush & ~i_stall;
  assign w_retire  = w_load_en & i_valid;

  // Write-back source mux; 11 aliases the ALU result.
  always_comb begin
    w_rd_data = i_alu_data;
    case (i_wb_sel)
      SEL_ALU:  w_rd_data = i_alu_data;
      SEL_LOAD: w_rd_data = w_ld_aligned;
      SEL_LINK: w_rd_data = w_link;
      default:  w_rd_data = i_alu_data;
    endcase
  end

  // ---- MEM -> WB boundary ----
  // MEM/WB register: flush inserts a zeroed bubble, stall holds, else capture.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd_wren_p1  <= 1'b0;
      r_rd_addr_p1  <= 5'd0;
      r_rd_data_p1  <= 32'd0;
      r_wb_valid_p1 <= 1'b0;
      r_wb_pc_p1    <= 32'd0;
    end else if (i_flush) begin
      r_rd_wren_p1  <= 1'b0;
      r_rd_addr_p1  <= 5'd0;
      r_rd_data_p1  <= 32'd0;
      r_wb_valid_p1 <= 1'b0;
      r_wb_pc_p1    <= 32'd0;
    end else if (!i_stall) begin
      r_rd_wren_p1  <= w_rd_wren;
      r_rd_addr_p1  <= w_rd_addr;
      r_rd_data_p1  <= w_rd_data;
      r_wb_valid_p1 <= i_valid;
      r_wb_pc_p1    <= i_pc;
    end
  end

  // Retired-instruction counter; wraps naturally at CNT_W bits.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign o_rd_wren  = r_rd_wren_p1;
  assign o_rd_addr  = r_rd_addr_p1;
  assign o_rd_data  = r_rd_data_p1;
  assign o_wb_valid = r_wb_valid_p1;
  assign o_wb_pc    = r_wb_pc_p1;
  assign o_instret  = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage: a 32-bit-counter instance for the
// datapath checks and a 4-bit-counter instance for the wrap check.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valid;
  logic [31:0] instruct;
  logic [31:0] pc;
  logic [31:0] alu_data;
  logic [31:0] ld_data;
  logic        rd_wren;
  logic [1:0]  wb_sel;

  logic        rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        wb_valid_o;
  logic [31:0] wb_pc_o;
  logic [31:0] instret_o;

  logic        s_rd_wren_o;
  logic [4:0]  s_rd_addr_o;
  logic [31:0] s_rd_data_o;
  logic        s_wb_valid_o;
  logic [31:0] s_wb_pc_o;
  logic [3:0]  s_instret_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_instret;

  writeback_stage #(.CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_instruct(instruct), .i_pc(pc), .i_alu_data(alu_data),
    .i_ld_data(ld_data), .i_rd_wren(rd_wren), .i_wb_sel(wb_sel),
    .o_rd_wren(rd_wren_o), .o_rd_addr(rd_addr_o), .o_rd_data(rd_data_o),
    .o_wb_valid(wb_valid_o), .o_wb_pc(wb_pc_o), .o_instret(instret_o)
  );

  writeback_stage #(.CNT_W(4)) dut_small (
    .i_clk(clk), .i_rst(rst_n), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_instruct(instruct), .i_pc(pc), .i_alu_data(alu_data),
    .i_ld_data(ld_data), .i_rd_wren(rd_wren), .i_wb_sel(wb_sel),
    .o_rd_wren(s_rd_wren_o), .o_rd_addr(s_rd_addr_o), .o_rd_data(s_rd_data_o),
    .o_wb_valid(s_wb_valid_o), .o_wb_pc(s_wb_pc_o), .o_instret(s_instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set up the MEM-stage inputs for one instruction.
  task automatic drive(input logic v, input logic [2:0] f3, input logic [4:0] rd,
                       input logic we, input logic [1:0] sel, input logic [31:0] p,
                       input logic [31:0] alu, input logic [31:0] ld);
    valid    = v;
    instruct = {17'h0, f3, rd, 7'b0000011};
    rd_wren  = we;
    wb_sel   = sel;
    pc       = p;
    alu_data = alu;
    ld_data  = ld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 3'd0, 5'd9, 1'b1, 2'b00, 32'h40, 32'hDEAD_BEEF, 32'h0);
    tick();
    tick();
    n_checks++;
    if ({rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o} !== 103'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wren=%0b addr=%0d data=%h valid=%0b pc=%h instret=%0d, want all 0",
               rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o);
    end
    n_checks++;
    if (s_instret_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_small_instret: got %0d want 0", s_instret_o);
    end
    rst_n = 1'b1;
    exp_instret = 32'd0;
  endtask

  task automatic test_alu();
    drive(1'b1, 3'd0, 5'd5, 1'b1, 2'b00, 32'h0000_0200, 32'h1234_5678, 32'h0);
    tick();
    exp_instret = exp_instret + 1;
    n_checks++;
    if ({rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o} !==
        {1'b1, 5'd5, 32'h1234_5678, 1'b1, 32'h0000_0200, 32'd1}) begin
      n_fail++;
      $display("FAIL alu_write: got wren=%0b addr=%0d data=%h valid=%0b pc=%h instret=%0d, want 1 5 12345678 1 00000200 1",
               rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o);
    end
    // wb_sel=11 also selects the ALU result
    drive(1'b1, 3'd0, 5'd6, 1'b1, 2'b11, 32'h0000_0204, 32'hCAFE_0001, 32'hFFFF_FFFF);
    tick();
    exp_instret = exp_instret + 1;
    n_checks++;
    if (rd_data_o !== 32'hCAFE_0001 || rd_addr_o !== 5'd6) begin
      n_fail++;
      $display("FAIL alu_sel11: got addr=%0d data=%h want 6 cafe0001", rd_addr_o, rd_data_o);
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3  [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011};
    logic [1:0]  off [8] = '{2'd1,   2'd3,   2'd2,   2'd2,   2'd3,   2'd1,   2'd0,   2'd2};
    logic [31:0] exp [8] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                             32'h0000_80FF, 32'h80FF_7F01, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, f3[i], 5'd3, 1'b1, 2'b01, 32'h300 + 32'(i * 4),
            32'h0000_1000 | {30'h0, off[i]}, 32'h80FF_7F01);
      tick();
      exp_instret = exp_instret + 1;
      n_checks++;
      if (rd_data_o !== exp[i] || rd_wren_o !== 1'b1) begin
        n_fail++;
        $display("FAIL load_align[%0d] f3=%0d off=%0d: got data=%h wren=%0b want %h 1",
                 i, f3[i], off[i], rd_data_o, rd_wren_o, exp[i]);
      end
    end
  endtask

  task automatic test_jal();
    drive(1'b1, 3'd0, 5'd1, 1'b1, 2'b10, 32'h0000_0100, 32'h5555_5555, 32'h0);
    tick();
    exp_instret = exp_instret + 1;
    n_checks++;
    if (rd_data_o !== 32'h0000_0104) begin
      n_fail++;
      $display("FAIL jal_link: got %h want 00000104", rd_data_o);
    end
    drive(1'b1, 3'd0, 5'd1, 1'b1, 2'b10, 32'hFFFF_FFFC, 32'h5555_5555, 32'h0);
    tick();
    exp_instret = exp_instret + 1;
    n_checks++;
    if (rd_data_o !== 32'h0000_0000 || wb_pc_o !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL jal_link_wrap: got data=%h pc=%h want 00000000 fffffffc", rd_data_o, wb_pc_o);
    end
  endtask

  task automatic test_x0_and_bubble();
    drive(1'b1, 3'd0, 5'd0, 1'b1, 2'b00, 32'h0000_0400, 32'h0000_00AA, 32'h0);
    tick();
    exp_instret = exp_instret + 1;
    n_checks++;
    if (rd_wren_o !== 1'b0 || wb_valid_o !== 1'b1 || instret_o !== exp_instret) begin
      n_fail++;
      $display("FAIL x0_suppress: got wren=%0b valid=%0b instret=%0d want 0 1 %0d",
               rd_wren_o, wb_valid_o, instret_o, exp_instret);
    end
    // Bubble: data still captured, no write, no retire
    drive(1'b0, 3'd0, 5'd7, 1'b1, 2'b00, 32'h0000_0404, 32'h0000_00BB, 32'h0);
    tick();
    n_checks++;
    if ({rd_wren_o, wb_valid_o, rd_addr_o, rd_data_o, instret_o} !==
        {1'b0, 1'b0, 5'd7, 32'h0000_00BB, exp_instret}) begin
      n_fail++;
      $display("FAIL bubble: got wren=%0b valid=%0b addr=%0d data=%h instret=%0d want 0 0 7 000000bb %0d",
               rd_wren_o, wb_valid_o, rd_addr_o, rd_data_o, instret_o, exp_instret);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 3'd0, 5'd12, 1'b1, 2'b00, 32'h0000_0800, 32'h0BAD_F00D, 32'h0);
    tick();
    exp_instret = exp_instret + 1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 5'(20 + i), 1'b1, 2'b10, 32'h900 + 32'(i), 32'h1111_0000 + 32'(i), 32'h0);
      tick();
      n_checks++;
      if ({rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o} !==
          {1'b1, 5'd12, 32'h0BAD_F00D, 1'b1, 32'h0000_0800, exp_instret}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got wren=%0b addr=%0d data=%h valid=%0b pc=%h instret=%0d want 1 12 0badf00d 1 00000800 %0d",
                 i, rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o, exp_instret);
      end
    end
    flush = 1'b1;
    tick();
    n_checks++;
    if ({rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o} !=
        {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, exp_instret}) begin
      n_fail++;
      $display("FAIL stall_and_flush: got wren=%0b addr=%0d data=%h valid=%0b pc=%h instret=%0d want 0 0 0 0 0 %0d",
               rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o, exp_instret);
    end
    stall = 1'b0;
    flush = 1'b0;
    // Capture resumes once both are released
    drive(1'b1, 3'd0, 5'd13, 1'b1, 2'b00, 32'h0000_0A00, 32'h7777_7777, 32'h0);
    tick();
    exp_instret = exp_instret + 1;
    n_checks++;
    if (rd_data_o !== 32'h7777_7777 || instret_o !== exp_instret) begin
      n_fail++;
      $display("FAIL resume_after_flush: got data=%h instret=%0d want 77777777 %0d",
               rd_data_o, instret_o, exp_instret);
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_instret = 32'd0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'd0, 5'd2, 1'b1, 2'b00, 32'(i * 4), 32'(i), 32'h0);
      tick();
    end
    n_checks++;
    if (s_instret_o !== 4'd1) begin
      n_fail++;
      $display("FAIL counter_wrap: got %0d want 1", s_instret_o);
    end
    n_checks++;
    if (instret_o !== 32'd17) begin
      n_fail++;
      $display("FAIL counter_17: got %0d want 17", instret_o);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'd0, 5'd4, 1'b1, 2'b00, 32'h0000_0C00, 32'hABCD_EF01, 32'h0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o, s_instret_o} !== 107'd0) begin
      n_fail++;
      $display("FAIL async_reset: got wren=%0b addr=%0d data=%h valid=%0b pc=%h instret=%0d small=%0d want all 0",
               rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, wb_pc_o, instret_o, s_instret_o);
    end
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (rd_data_o !== 32'hABCD_EF01 || instret_o !== 32'd1 || rd_wren_o !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_after_reset: got data=%h instret=%0d wren=%0b want abcdef01 1 1",
               rd_data_o, instret_o, rd_wren_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_jal();
    test_x0_and_bubble();
    test_stall_flush();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (WB) stage of the five-stage RV32I pipeline. It is the producer side of the register-file write port that the decode stage consumes.
- Registers MEM-stage results in a MEM/WB pipeline register with stall and flush control.
- Aligns and extends load data, selects the write-back source, and drives rd write-enable/address/data to the register file.
- Also maintains a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter o_instret.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_stall  input  1  hold the MEM/WB register.
- i_flush  input  1  load a bubble into the MEM/WB register.
- i_valid  input  1  MEM-stage slot holds a real instruction.
- i_instruct  input  32  MEM-stage instruction; [11:7] is rd, [14:12] is funct3.
- i_pc  input  32  MEM-stage PC.
- i_alu_data  input  32  ALU result, also the load address.
- i_ld_data  input  32  raw aligned word from the LSU.
- i_rd_wren  input  1  decoded register-write control.
- i_wb_sel  input  2  write-back source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- o_rd_wren  output  1  register-file write enable.
- o_rd_addr  output  5  register-file write address.
- o_rd_data  output  32  register-file write data.
- o_wb_valid  output  1  WB slot holds a real instruction.
- o_wb_pc  output  32  PC of the WB-slot instruction.
- o_instret  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (i_rst=0, asynchronous): every output and internal register goes to 0, and o_instret goes to 0.
- All outputs are flop outputs. Latency is 1 cycle from MEM inputs to WB outputs. There is no combinational path from inputs to outputs.
- Priority at each rising edge: flush > stall > normal load.
  - Flush: o_wb_valid=0, o_rd_wren=0. o_rd_addr, o_rd_data and o_wb_pc go to 0.
  - Stall (no flush): all WB registers hold their values. A held o_rd_wren=1 rewrites the same value, which is harmless.
  - Normal: capture the new values computed below.
- Captured write enable: o_rd_wren = i_valid & i_rd_wren & (i_instruct[11:7] != 0). Writes to x0 are always suppressed.
- Captured address and PC: o_rd_addr = i_instruct[11:7]; o_wb_pc = i_pc; o_wb_valid = i_valid.
- Load alignment (wb_sel=01). Byte offset off = i_alu_data[1:0].
  - funct3 000 (LB): byte off, sign-extended.
  - funct3 100 (LBU): byte off, zero-extended.
  - funct3 001 (LH): halfword selected by i_alu_data[1]; bit 0 is ignored; sign-extended.
  - funct3 101 (LHU): as LH, zero-extended.
  - funct3 010 (LW) and reserved funct3 011/110/111: full word; off is ignored.
- Data select:
  - 00 and 11: i_alu_data.
  - 01: aligned load value.
  - 10: i_pc + 4, modulo 2^32 (0xFFFFFFFC gives 0x00000000).
- Bubbles: when i_valid=0, o_rd_data is still captured, but o_rd_wren=0 so nothing is written.
- Counter: o_instret increments by 1 on each normal (non-stall, non-flush) edge with i_valid=1. It wraps from all-ones to 0 and does not change on stall or flush.
- Simultaneous i_stall and i_flush: flush wins, and the counter does not increment.
- Reset asserted mid-operation clears immediately, with no dependence on a clock edge. Normal capture resumes on the first rising edge after reset deasserts.

Test Plan:
- Reset then release; i_valid=1, wb_sel=00, rd=5, i_alu_data=0x1234_5678 -> next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0x12345678, o_instret=1.
- Load alignment with i_ld_data=0x80FF_7F01:
  - LB, off=1 -> 0x0000007F.
  - LB, off=3 -> 0xFFFFFF80.
  - LBU, off=2 -> 0x000000FF.
  - LH, off=2 -> 0xFFFF80FF.
  - LHU, off=3 -> 0x000080FF.
  - LW, off=1 -> 0x80FF7F01.
- JAL with wb_sel=10, i_pc=0x0000_0100 -> o_rd_data=0x00000104. With i_pc=0xFFFF_FFFC -> o_rd_data=0x00000000.
- rd=0 with i_rd_wren=1 -> o_rd_wren=0; o_wb_valid=1 and o_instret still increments.
- Stall for 3 cycles while the inputs change -> outputs and o_instret frozen. Assert stall and flush together -> o_wb_valid=0, o_rd_wren=0, counter unchanged.
- Counter wrap: use CNT_W=4 and retire 17 valid instructions -> o_instret=1. Assert reset asynchronously between clock edges -> all outputs 0 immediately.
